// File: rtl/br_rsv_station.sv
// Reservation station for branch/jump ops: holds entries until both operands are valid, snooping the CDB.
// Latency: dispatch-ready or last CDB wakeup -> iss_valid two edges later; issue output is registered.
// Backpressure: disp_ready drops when every slot is occupied; the compare unit never stalls issue.
module br_rsv_station #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [6:0]       disp_op_code,
  input  logic [2:0]       disp_cmp_opcode,
  input  logic [31:0]      disp_pc,
  input  logic [31:0]      disp_imm,
  input  logic [TAG_W-1:0] disp_rob_tag,
  input  logic             disp_rs1_rdy,
  input  logic             disp_rs2_rdy,
  input  logic [31:0]      disp_rs1_val,
  input  logic [31:0]      disp_rs2_val,
  input  logic [TAG_W-1:0] disp_rs1_tag,
  input  logic [TAG_W-1:0] disp_rs2_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic             iss_valid,
  output logic [6:0]       iss_op_code,
  output logic [2:0]       iss_cmp_opcode,
  output logic [31:0]      iss_a,
  output logic [31:0]      iss_b,
  output logic [31:0]      iss_pc,
  output logic [31:0]      iss_imm,
  output logic [TAG_W-1:0] iss_tag
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_WAIT  = 2'd1,
    SLOT_READY = 2'd2
  } slot_st_e;

  typedef struct packed {
    logic [6:0]       op_code;
    logic [2:0]       cmp_opcode;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic [TAG_W-1:0] rob_tag;
    logic             rs1_rdy;
    logic [31:0]      rs1_val;
    logic [TAG_W-1:0] rs1_tag;
    logic             rs2_rdy;
    logic [31:0]      rs2_val;
    logic [TAG_W-1:0] rs2_tag;
  } slot_t;

  slot_st_e         st_q   [DEPTH];
  slot_st_e         st_d   [DEPTH];
  slot_t            slot_q [DEPTH];
  slot_t            slot_d [DEPTH];

  logic             free_vld;
  logic [IDX_W-1:0] free_idx;
  logic             sel_vld;
  logic [IDX_W-1:0] sel_idx;
  logic             disp_fire;
  logic             issue_fire;
  slot_t            disp_slot;

  // Lowest-index free slot and lowest-index ready slot, from registered state only.
  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    sel_vld  = 1'b0;
    sel_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (st_q[i] == SLOT_EMPTY) begin
        free_vld = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (st_q[i] == SLOT_READY) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  assign disp_ready = free_vld;
  assign disp_fire  = disp_valid & free_vld & ~flush;
  assign issue_fire = sel_vld & ~flush;

  // Incoming entry, with a same-cycle CDB match counting as a captured operand.
  always_comb begin
    disp_slot.op_code    = disp_op_code;
    disp_slot.cmp_opcode = disp_cmp_opcode;
    disp_slot.pc         = disp_pc;
    disp_slot.imm        = disp_imm;
    disp_slot.rob_tag    = disp_rob_tag;
    disp_slot.rs1_tag    = disp_rs1_tag;
    disp_slot.rs2_tag    = disp_rs2_tag;
    disp_slot.rs1_rdy    = disp_rs1_rdy | (cdb_valid & (cdb_tag == disp_rs1_tag));
    disp_slot.rs2_rdy    = disp_rs2_rdy | (cdb_valid & (cdb_tag == disp_rs2_tag));
    disp_slot.rs1_val    = disp_rs1_rdy ? disp_rs1_val : cdb_value;
    disp_slot.rs2_val    = disp_rs2_rdy ? disp_rs2_val : cdb_value;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      st_d[i]   = st_q[i];
      slot_d[i] = slot_q[i];
      if (flush) begin
        st_d[i] = SLOT_EMPTY;
      end else begin
        case (st_q[i])
          SLOT_EMPTY: begin
            if (disp_fire && (free_idx == IDX_W'(i))) begin
              slot_d[i] = disp_slot;
              st_d[i]   = (disp_slot.rs1_rdy && disp_slot.rs2_rdy) ? SLOT_READY : SLOT_WAIT;
            end
          end
          SLOT_WAIT: begin
            if (!slot_q[i].rs1_rdy && cdb_valid && (cdb_tag == slot_q[i].rs1_tag)) begin
              slot_d[i].rs1_rdy = 1'b1;
              slot_d[i].rs1_val = cdb_value;
            end
            if (!slot_q[i].rs2_rdy && cdb_valid && (cdb_tag == slot_q[i].rs2_tag)) begin
              slot_d[i].rs2_rdy = 1'b1;
              slot_d[i].rs2_val = cdb_value;
            end
            if (slot_d[i].rs1_rdy && slot_d[i].rs2_rdy) begin
              st_d[i] = SLOT_READY;
            end
          end
          SLOT_READY: begin
            if (sel_vld && (sel_idx == IDX_W'(i))) begin
              st_d[i] = SLOT_EMPTY;
            end
          end
          default: st_d[i] = SLOT_EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]   <= SLOT_EMPTY;
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]   <= st_d[i];
        slot_q[i] <= slot_d[i];
      end
    end
  end

  // Issue register; data is only reloaded on an actual issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid      <= 1'b0;
      iss_op_code    <= '0;
      iss_cmp_opcode <= '0;
      iss_a          <= '0;
      iss_b          <= '0;
      iss_pc         <= '0;
      iss_imm        <= '0;
      iss_tag        <= '0;
    end else begin
      iss_valid <= issue_fire;
      if (issue_fire) begin
        iss_op_code    <= slot_q[sel_idx].op_code;
        iss_cmp_opcode <= slot_q[sel_idx].cmp_opcode;
        iss_a          <= slot_q[sel_idx].rs1_val;
        iss_b          <= slot_q[sel_idx].rs2_val;
        iss_pc         <= slot_q[sel_idx].pc;
        iss_imm        <= slot_q[sel_idx].imm;
        iss_tag        <= slot_q[sel_idx].rob_tag;
      end
    end
  end

endmodule

// File: tb/tb_br_rsv_station.sv
// Bench for br_rsv_station: directed scenarios plus randomized traffic against a slot-list model.
module tb_br_rsv_station;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int BUS_W = 7 + 3 + 128 + TAG_W;
  localparam logic [6:0] OP_BR   = 7'h63;
  localparam logic [6:0] OP_JAL  = 7'h6F;
  localparam logic [6:0] OP_JALR = 7'h67;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush, disp_valid, disp_ready;
  logic [6:0] disp_op_code;
  logic [2:0] disp_cmp_opcode;
  logic [31:0] disp_pc, disp_imm, disp_rs1_val, disp_rs2_val;
  logic [TAG_W-1:0] disp_rob_tag, disp_rs1_tag, disp_rs2_tag;
  logic disp_rs1_rdy, disp_rs2_rdy;
  logic cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0] cdb_value;
  logic iss_valid;
  logic [6:0] iss_op_code;
  logic [2:0] iss_cmp_opcode;
  logic [31:0] iss_a, iss_b, iss_pc, iss_imm;
  logic [TAG_W-1:0] iss_tag;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  br_rsv_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op_code(disp_op_code), .disp_cmp_opcode(disp_cmp_opcode),
    .disp_pc(disp_pc), .disp_imm(disp_imm), .disp_rob_tag(disp_rob_tag),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .iss_valid(iss_valid), .iss_op_code(iss_op_code), .iss_cmp_opcode(iss_cmp_opcode),
    .iss_a(iss_a), .iss_b(iss_b), .iss_pc(iss_pc), .iss_imm(iss_imm), .iss_tag(iss_tag)
  );

  // Model: a list of occupied slots, each operand either known or waiting on a tag.
  typedef struct {
    bit               used;
    bit               a_ok;
    bit               b_ok;
    logic [31:0]      a, b, pc, imm;
    logic [TAG_W-1:0] ta, tb, tag;
    logic [6:0]       op;
    logic [2:0]       cmp;
  } ment_t;

  ment_t m[DEPTH];
  bit exp_vld;
  logic [BUS_W-1:0] exp_bus;

  function automatic logic [BUS_W-1:0] iss_bus();
    return {iss_op_code, iss_cmp_opcode, iss_a, iss_b, iss_pc, iss_imm, iss_tag};
  endfunction

  function automatic bit m_has_free();
    for (int i = 0; i < DEPTH; i++) if (!m[i].used) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < DEPTH; i++) m[i].used = 1'b0;
    exp_vld = 1'b0;
  endtask

  // Advance the model with the currently driven inputs, then clock the DUT.
  task automatic step();
    int sel = -1;
    int fr = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel < 0 && m[i].used && m[i].a_ok && m[i].b_ok) sel = i;
      if (fr < 0 && !m[i].used) fr = i;
    end
    if (flush) begin
      m_clear();
    end else begin
      exp_vld = (sel >= 0);
      if (sel >= 0) begin
        exp_bus = {m[sel].op, m[sel].cmp, m[sel].a, m[sel].b, m[sel].pc, m[sel].imm, m[sel].tag};
        m[sel].used = 1'b0;
      end
      if (cdb_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (m[i].used && !m[i].a_ok && m[i].ta == cdb_tag) begin m[i].a = cdb_value; m[i].a_ok = 1'b1; end
          if (m[i].used && !m[i].b_ok && m[i].tb == cdb_tag) begin m[i].b = cdb_value; m[i].b_ok = 1'b1; end
        end
      end
      if (disp_valid && fr >= 0) begin
        m[fr].used = 1'b1;
        m[fr].op   = disp_op_code;
        m[fr].cmp  = disp_cmp_opcode;
        m[fr].pc   = disp_pc;
        m[fr].imm  = disp_imm;
        m[fr].tag  = disp_rob_tag;
        m[fr].ta   = disp_rs1_tag;
        m[fr].tb   = disp_rs2_tag;
        m[fr].a_ok = disp_rs1_rdy || (cdb_valid && disp_rs1_tag == cdb_tag);
        m[fr].b_ok = disp_rs2_rdy || (cdb_valid && disp_rs2_tag == cdb_tag);
        m[fr].a    = disp_rs1_rdy ? disp_rs1_val : cdb_value;
        m[fr].b    = disp_rs2_rdy ? disp_rs2_val : cdb_value;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    flush = 1'b0; disp_valid = 1'b0; disp_op_code = '0; disp_cmp_opcode = '0;
    disp_pc = '0; disp_imm = '0; disp_rob_tag = '0;
    disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0; disp_rs1_val = '0; disp_rs2_val = '0;
    disp_rs1_tag = '0; disp_rs2_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
  endtask

  task automatic drive_disp(input logic [6:0] op, input logic [2:0] cmp, input logic [31:0] pc,
                            input logic [31:0] imm, input logic [TAG_W-1:0] tag,
                            input logic r1, input logic [31:0] v1, input logic [TAG_W-1:0] t1,
                            input logic r2, input logic [31:0] v2, input logic [TAG_W-1:0] t2);
    disp_valid = 1'b1; disp_op_code = op; disp_cmp_opcode = cmp; disp_pc = pc; disp_imm = imm;
    disp_rob_tag = tag; disp_rs1_rdy = r1; disp_rs1_val = v1; disp_rs1_tag = t1;
    disp_rs2_rdy = r2; disp_rs2_val = v2; disp_rs2_tag = t2;
  endtask

  task automatic drive_cdb(input logic [TAG_W-1:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", iss_valid); end
    total++; if (iss_bus() !== '0) begin bad++; $display("FAIL reset_bus got=%h want=0", iss_bus()); end
    rst_n = 1'b1;
    #1;
    total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b want=1", disp_ready); end
  endtask

  task automatic test_basic();
    logic [BUS_W-1:0] want;
    drive_disp(OP_BR, 3'b000, 32'h100, 32'h20, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd5, 4'd0);
    step();
    set_idle();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL basic_early got=%b want=0", iss_valid); end
    step();
    want = {OP_BR, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 4'd3};
    total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL basic_vld got=%b want=1", iss_valid); end
    total++; if (iss_bus() !== want) begin bad++; $display("FAIL basic_data got=%h want=%h", iss_bus(), want); end
    step();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL basic_after got=%b want=0", iss_valid); end
  endtask

  task automatic test_wakeup();
    drive_disp(OP_BR, 3'b001, 32'h200, 32'h40, 4'd1, 1'b0, 32'd0, 4'd7, 1'b1, 32'd9, 4'd0);
    step();
    set_idle();
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL wake_idle%0d got=%b want=0", k, iss_valid); end
    end
    drive_cdb(4'd7, 32'h42);
    step();
    set_idle();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL wake_early got=%b want=0", iss_valid); end
    step();
    total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL wake_vld got=%b want=1", iss_valid); end
    total++; if ({iss_a, iss_b, iss_tag} !== {32'h42, 32'd9, 4'd1}) begin
      bad++; $display("FAIL wake_data got=%h/%h/%h want=42/9/1", iss_a, iss_b, iss_tag);
    end
  endtask

  task automatic test_bypass();
    drive_disp(OP_BR, 3'b100, 32'h300, 32'h8, 4'd5, 1'b0, 32'd0, 4'd2, 1'b1, 32'd1, 4'd0);
    drive_cdb(4'd2, 32'hFFFF_FFFF);
    step();
    set_idle();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL byp_early got=%b want=0", iss_valid); end
    step();
    total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL byp_vld got=%b want=1", iss_valid); end
    total++; if ({iss_a, iss_b, iss_pc} !== {32'hFFFF_FFFF, 32'd1, 32'h300}) begin
      bad++; $display("FAIL byp_data got=%h/%h/%h want=ffffffff/1/300", iss_a, iss_b, iss_pc);
    end
    step();
  endtask

  task automatic test_full();
    for (int k = 0; k < DEPTH; k++) begin
      drive_disp(OP_BR, 3'b101, 32'h400 + 32'(k * 4), 32'd0, 4'(k + 8), 1'b0, 32'd0, 4'd6, 1'b1, 32'(k), 4'd0);
      step();
    end
    set_idle();
    total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL full_rdy got=%b want=0", disp_ready); end
    drive_disp(OP_BR, 3'b000, 32'hDEAD, 32'd0, 4'd15, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
    step();
    set_idle();
    total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL full_ignored got=%b want=0", disp_ready); end
    drive_cdb(4'd6, 32'h10);
    step();
    set_idle();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL full_early got=%b want=0", iss_valid); end
    for (int k = 0; k < DEPTH; k++) begin
      step();
      total++; if ({iss_valid, iss_pc, iss_a, iss_b} !== {1'b1, 32'h400 + 32'(k * 4), 32'h10, 32'(k)}) begin
        bad++; $display("FAIL full_issue%0d got=%b/%h/%h/%h want=1/%h/10/%h", k, iss_valid, iss_pc, iss_a, iss_b,
                        32'h400 + 32'(k * 4), k);
      end
      if (k == 0) begin
        total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL full_reopen got=%b want=1", disp_ready); end
      end
    end
    step();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL full_drain got=%b want=0", iss_valid); end
  endtask

  task automatic test_flush();
    drive_disp(OP_BR, 3'b000, 32'h500, 32'd0, 4'd1, 1'b0, 32'd0, 4'd8, 1'b1, 32'd3, 4'd0);
    step();
    drive_disp(OP_JALR, 3'b000, 32'h504, 32'd0, 4'd2, 1'b1, 32'd4, 4'd0, 1'b0, 32'd0, 4'd9);
    step();
    drive_disp(OP_JAL, 3'b000, 32'h508, 32'd0, 4'd3, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
    step();
    drive_disp(OP_BR, 3'b000, 32'h50C, 32'd0, 4'd4, 1'b1, 32'd7, 4'd0, 1'b1, 32'd7, 4'd0);
    flush = 1'b1;
    step();
    set_idle();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL flush_vld got=%b want=0", iss_valid); end
    total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL flush_rdy got=%b want=1", disp_ready); end
    drive_cdb(4'd8, 32'h88);
    step();
    drive_cdb(4'd9, 32'h99);
    step();
    set_idle();
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL flush_quiet%0d got=%b want=0", k, iss_valid); end
    end
  endtask

  task automatic test_async_reset();
    drive_disp(OP_BR, 3'b110, 32'h600, 32'h4, 4'd6, 1'b1, 32'h11, 4'd0, 1'b1, 32'h22, 4'd0);
    step();
    drive_disp(OP_BR, 3'b111, 32'h604, 32'h4, 4'd7, 1'b0, 32'd0, 4'hA, 1'b1, 32'h33, 4'd0);
    step();
    set_idle();
    total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b want=1", iss_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    m_clear();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL arst_vld got=%b want=0", iss_valid); end
    total++; if (iss_bus() !== '0) begin bad++; $display("FAIL arst_bus got=%h want=0", iss_bus()); end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL arst_rdy got=%b want=1", disp_ready); end
    drive_cdb(4'hA, 32'hAA);
    step();
    set_idle();
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL arst_quiet%0d got=%b want=0", k, iss_valid); end
    end
  endtask

  task automatic test_random();
    logic [6:0] ops[3];
    ops[0] = OP_BR; ops[1] = OP_JAL; ops[2] = OP_JALR;
    for (int n = 0; n < 3000; n++) begin
      set_idle();
      flush = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 1) == 1) begin
        drive_disp(ops[$urandom_range(0, 2)], 3'($urandom), $urandom, $urandom, 4'($urandom),
                   ($urandom_range(0, 2) == 0), $urandom, 4'($urandom_range(0, 7)),
                   ($urandom_range(0, 2) != 0), $urandom, 4'($urandom_range(0, 7)));
      end
      if ($urandom_range(0, 4) < 2) drive_cdb(4'($urandom_range(0, 7)), $urandom);
      #1;
      total++; if (disp_ready !== m_has_free()) begin
        bad++; $display("FAIL rnd_rdy cyc=%0d got=%b want=%b", n, disp_ready, m_has_free());
      end
      step();
      total++; if (iss_valid !== exp_vld) begin
        bad++; $display("FAIL rnd_vld cyc=%0d got=%b want=%b", n, iss_valid, exp_vld);
      end
      if (exp_vld) begin
        total++; if (iss_bus() !== exp_bus) begin
          bad++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", n, iss_bus(), exp_bus);
        end
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    m_clear();
    exp_bus = '0;
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_full();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
